vec_mem_sequencer: RTL and testbench

- Memory-stage consumer of the decode-generated memory controls (MemWrite, MemtoReg-as-read, VecData).
- Turns one scalar or 128-bit vector load/store into a sequence of 32-bit beats on a req/ack word-memory port.
- Stalls the pipeline until the access completes, then presents registered load data for writeback.
- Sits between the MEM pipeline register and data memory; vector accesses carry the AES state.

---
 rtl/vec_mem_pkg.sv | 17 +
 rtl/vec_lane_buffer.sv | 31 +++
 rtl/vec_mem_sequencer.sv | 120 ++++++++++++
 tb/tb_vec_mem_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared constants and state encoding for the vector memory sequencer.
package vec_mem_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned LANES          = 4;
    localparam int unsigned VEC_W          = DATA_W * LANES;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BEAT_W         = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vec_lane_buffer.sv
// Load-data holding register: LANES words, one written per acked read beat.
module vec_lane_buffer
    import vec_mem_pkg::*;
(
    input  logic                clk,
    input  logic                clr_i,
    input  logic                we_i,
    input  logic [BEAT_W-1:0]   lane_i,
    input  logic [DATA_W-1:0]   wd_i,
    output logic [VEC_W-1:0]    data_o
);

    logic [DATA_W-1:0] lanes_q [LANES];

    // Clear has priority; otherwise write the addressed lane, others hold.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else if (we_i) begin
            lanes_q[lane_i] <= wd_i;
        end
    end

    // Flatten lanes, lane 0 in the least significant word.
    for (genvar g = 0; g < LANES; g++) begin : g_flat
        assign data_o[g*DATA_W +: DATA_W] = lanes_q[g];
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Splits a scalar or vector load/store into 32-bit req/ack beats and stalls
// the pipeline until the access finishes.
module vec_mem_sequencer
    import vec_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                MemWriteM,
    input  logic                MemReadM,
    input  logic                VecDataM,
    input  logic [ADDR_W-1:0]   AddrM,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic [VEC_W-1:0]    WriteDataVM,
    output logic                StallM,
    output logic [DATA_W-1:0]   ReadDataM,
    output logic [VEC_W-1:0]    ReadDataVM,
    output logic                MemReq,
    output logic                MemWE,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic [DATA_W-1:0]   MemWD,
    input  logic [DATA_W-1:0]   MemRD,
    input  logic                MemAck
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                wr_q, wr_d;
    logic                vec_q, vec_d;
    logic                req;
    logic                busy;
    logic [BEAT_W-1:0]   last_beat;
    logic                lane_we;

    assign req       = MemWriteM | MemReadM;
    assign busy      = (state_q == BUSY);
    assign last_beat = vec_q ? BEAT_W'(LANES - 1) : '0;
    assign lane_we   = busy & MemAck & ~wr_q;

    // State and access-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            wr_q    <= 1'b0;
            vec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            wr_q    <= wr_d;
            vec_q   <= vec_d;
        end
    end

    // Next state, beat sequencing and memory/pipeline handshake outputs.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        wr_d    = wr_q;
        vec_d   = vec_q;
        StallM  = 1'b0;
        MemReq  = 1'b0;
        MemWE   = 1'b0;
        MemAddr = base_q + ADDR_W'(ADDR_W'(beat_q) * ADDR_W'(BYTES_PER_WORD));
        MemWD   = vec_q ? WriteDataVM[beat_q*DATA_W +: DATA_W] : WriteDataM;

        unique case (state_q)
            IDLE: begin
                StallM = req;
                if (req) begin
                    base_d  = AddrM;
                    wr_d    = MemWriteM;
                    vec_d   = VecDataM;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                StallM = 1'b1;
                MemReq = 1'b1;
                MemWE  = wr_q;
                if (MemAck) begin
                    if (beat_q == last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset aborts immediately: no beat issued, pipeline released.
        if (rst) begin
            StallM = 1'b0;
            MemReq = 1'b0;
            MemWE  = 1'b0;
        end
    end

    vec_lane_buffer u_lane_buffer (
        .clk    (clk),
        .clr_i  (rst),
        .we_i   (lane_we),
        .lane_i (beat_q),
        .wd_i   (MemRD),
        .data_o (ReadDataVM)
    );

    assign ReadDataM = ReadDataVM[DATA_W-1:0];

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with hand-computed beat expectations.
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         MemWriteM, MemReadM, VecDataM;
    logic [31:0]  AddrM, WriteDataM;
    logic [127:0] WriteDataVM;
    logic         StallM;
    logic [31:0]  ReadDataM;
    logic [127:0] ReadDataVM;
    logic         MemReq, MemWE;
    logic [31:0]  MemAddr, MemWD, MemRD;
    logic         MemAck;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_vec = '0;

    always #5 clk = ~clk;

    vec_mem_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .MemWriteM   (MemWriteM),
        .MemReadM    (MemReadM),
        .VecDataM    (VecDataM),
        .AddrM       (AddrM),
        .WriteDataM  (WriteDataM),
        .WriteDataVM (WriteDataVM),
        .StallM      (StallM),
        .ReadDataM   (ReadDataM),
        .ReadDataVM  (ReadDataVM),
        .MemReq      (MemReq),
        .MemWE       (MemWE),
        .MemAddr     (MemAddr),
        .MemWD       (MemWD),
        .MemRD       (MemRD),
        .MemAck      (MemAck)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access: accept cycle, beats with k wait cycles each, then DONE.
    task automatic run_access(input string tag, input logic wr, input logic rd,
                              input logic vec, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [127:0] wdv,
                              input logic [127:0] rdv, input int k, input bit noise);
        int          stall_cnt;
        int          beats;
        logic [31:0] ea;
        logic [31:0] ewd;
        stall_cnt = 0;
        beats     = vec ? 4 : 1;
        tick();
        MemAck = 1'b0;
        MemWriteM = wr; MemReadM = rd; VecDataM = vec;
        AddrM = addr; WriteDataM = wd; WriteDataVM = wdv;
        #1;
        check({tag, "_accept_stall"}, StallM, 1'b1);
        check({tag, "_accept_req"}, MemReq, 1'b0);
        for (int b = 0; b < beats; b++) begin
            for (int w = 0; w <= k; w++) begin
                tick();
                MemAck = (w == k);
                MemRD  = rdv[b*32 +: 32];
                #1;
                if (StallM) stall_cnt++;
                ea  = addr + 32'(b * 4);
                ewd = vec ? wdv[b*32 +: 32] : wd;
                check({tag, "_req"}, MemReq, 1'b1);
                check({tag, "_addr"}, MemAddr, ea);
                check({tag, "_we"}, MemWE, wr);
                if (wr) check({tag, "_wd"}, MemWD, ewd);
            end
        end
        tick();
        MemAck = noise;
        MemRD  = 32'hBAAD_F00D;
        #1;
        if (rd && !wr) begin
            if (vec) exp_vec = rdv;
            else     exp_vec[31:0] = rdv[31:0];
        end
        check({tag, "_done_stall"}, StallM, 1'b0);
        check({tag, "_done_req"}, MemReq, 1'b0);
        check({tag, "_rdv"}, ReadDataVM, exp_vec);
        check({tag, "_rd"}, ReadDataM, exp_vec[31:0]);
        check({tag, "_stall_cycles"}, 128'(stall_cnt), 128'(beats * (k + 1)));
        MemWriteM = 1'b0; MemReadM = 1'b0; VecDataM = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        MemWriteM = 1'b0; MemReadM = 1'b0; VecDataM = 1'b0;
        AddrM = '0; WriteDataM = '0; WriteDataVM = '0;
        MemRD = '0; MemAck = 1'b0;
        tick(); tick();
        MemReadM = 1'b1;
        #1;
        check("rst_stall", StallM, 1'b0);
        check("rst_req", MemReq, 1'b0);
        check("rst_we", MemWE, 1'b0);
        check("rst_rdv", ReadDataVM, 128'h0);
        check("rst_rd", ReadDataM, 32'h0);
        MemReadM = 1'b0;
        tick();
        rst = 1'b0;

        // Scalar store, ack on the first BUSY cycle.
        run_access("sst", 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF,
                   128'h0, 128'h5555_5555, 0, 1'b0);
        tick();
        #1;
        check("sst_idle_stall", StallM, 1'b0);
        check("sst_idle_req", MemReq, 1'b0);

        // Best-case vector load.
        run_access("vld", 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0,
                   128'h0, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 0, 1'b0);

        // Vector store, two wait cycles per beat, stray ack in DONE.
        run_access("vst", 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0,
                   128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000,
                   128'hFFFF_FFFF_EEEE_EEEE_9999_9999_8888_8888, 2, 1'b1);
        tick();
        MemAck = 1'b1;
        MemRD  = 32'hBAAD_F00D;
        #1;
        check("stray_ack_req", MemReq, 1'b0);
        check("stray_ack_rdv", ReadDataVM, exp_vec);
        tick();
        MemAck = 1'b0;
        #1;
        check("stray_ack_rdv2", ReadDataVM, exp_vec);

        // Address wrap across 2^32.
        run_access("wrap", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0,
                   128'h0, 128'hA4A4_A4A4_A3A3_A3A3_A2A2_A2A2_A1A1_A1A1, 0, 1'b0);

        // Reset after beat 1 of a vector load.
        tick();
        MemReadM = 1'b1; VecDataM = 1'b1; AddrM = 32'h0000_0700;
        for (int b = 0; b < 2; b++) begin
            tick();
            MemAck = 1'b1;
            MemRD  = 32'h7070_0000 + 32'(b);
            #1;
            check("rstmid_addr", MemAddr, 32'h0000_0700 + 32'(b * 4));
        end
        tick();
        MemAck = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_req_now", MemReq, 1'b0);
        check("rstmid_stall_now", StallM, 1'b0);
        tick();
        rst = 1'b0;
        MemReadM = 1'b0; VecDataM = 1'b0;
        #1;
        exp_vec = '0;
        check("rstmid_req", MemReq, 1'b0);
        check("rstmid_stall", StallM, 1'b0);
        check("rstmid_rdv", ReadDataVM, exp_vec);
        run_access("after_rst", 1'b0, 1'b1, 1'b1, 32'h0000_0800, 32'h0,
                   128'h0, 128'h0D0D_0D0D_0C0C_0C0C_0B0B_0B0B_0A0A_0A0A, 0, 1'b0);

        // Vector load then scalar load back to back.
        run_access("b2b_v", 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0,
                   128'h0, 128'h1234_0004_1234_0003_1234_0002_1234_0001, 0, 1'b0);
        run_access("b2b_s", 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0,
                   128'h0, 128'hCAFE_F00D, 1, 1'b0);
        check("b2b_lanes", ReadDataVM, 128'h1234_0004_1234_0003_1234_0002_CAFE_F00D);

        // Write and read both requested: write only.
        run_access("both", 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h1357_9BDF,
                   128'h0, 128'h2468_ACE0, 0, 1'b0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
